dm_store_unit: RTL and testbench
================================

Name: dm_store_unit

Overview:
- Memory-stage data memory with a byte-lane store path: the writer side of the load-extension path in W.
- Accepts sw/sh/sb requests and performs lane alignment, byte-enable generation and misalignment/range checks.
- Writes a 1024-word array on the clock edge.
- Returns the raw aligned word at the addressed location; W-stage load extension consumes that word unchanged.

Parameters:
- DM_WORDS, 1024, number of 32-bit words in the array.
- ADDR_BITS, 10, word-index width; equals log2(DM_WORDS).

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store request for this cycle.
- StoreOp  input  2  00=sw, 01=sh, 10=sb, 11=reserved.
- Addr  input  32  byte address computed by the ALU.
- WData  input  32  store data (forwarded rt value).
- RData  output  32  raw word at word index Addr[ADDR_BITS+1:2]; combinational.
- ByteEn  output  4  byte lanes written this cycle; combinational; 0 when no write.
- StoreErr  output  1  combinational; high when a store request is rejected.
- ErrSticky  output  1  registered; set by any rejected store, cleared only by reset.
- StoreCount  output  32  registered count of committed stores.

Behaviour:
- Reset (asynchronous, active-high):
  - all DM_WORDS words = 0x00000000.
  - ErrSticky = 0, StoreCount = 0.
  - RData reads 0 while reset is held.
  - A store in the same cycle as reset is dropped.
- Word index: idx = Addr[ADDR_BITS+1:2].
- In-range: Addr[31:ADDR_BITS+2] == 0. Out-of-range stores are rejected. Out-of-range reads return mem[idx] (upper bits ignored).
- Lane alignment of write data:
  - sw: WData.
  - sh: {WData[15:0], WData[15:0]}.
  - sb: {4{WData[7:0]}}.
- Byte-enable generation (valid store only):
  - sw: 4'b1111.
  - sh: Addr[1]=0 -> 4'b0011; Addr[1]=1 -> 4'b1100.
  - sb: 4'b0001 << Addr[1:0].
- A store is rejected (StoreErr = 1) when MemWrite is high and any of these holds:
  - sw with Addr[1:0] != 0;
  - sh with Addr[0] = 1;
  - StoreOp = 11;
  - address out of range.
  On rejection, ByteEn = 0 and memory is unchanged.
- Commit: at the rising edge with MemWrite=1, StoreErr=0 and reset=0:
  - mem[idx] lanes with ByteEn set take the aligned data; the other lanes are untouched.
  - StoreCount increments by 1 and wraps modulo 2^32.
- Rejected store: at the rising edge ErrSticky <= 1 and StoreCount is unchanged.
- MemWrite=0: ByteEn = 0, StoreErr = 0, no state change. StoreOp and WData are don't-care.
- Read-during-write to the same word: RData shows the old word until the edge and the new word immediately after it. There is no bypass.
- Back-to-back stores to the same word on consecutive cycles accumulate lane by lane.
- Latency: store visible on RData one edge after the request; RData/ByteEn/StoreErr have zero latency.

Test Plan:
- Reset: after reset pulse, read Addr=0x0, 0x7FC, 0xFFC -> RData=0x00000000, StoreCount=0, ErrSticky=0.
- sw then read: sw 0x12345678 @0x10 -> ByteEn=1111 in the request cycle; next cycle RData@0x10=0x12345678; StoreCount=1.
- sb sequence, one per cycle:
  - Steps: sw 0xAABBCCDD @0x20; sb 0x11 @0x21; sh 0x2233 @0x22.
  - ByteEn per step: 0010 for the sb, 1100 for the sh.
  - Final RData@0x20 = 0x223311DD; StoreCount=3.
- Misaligned/illegal stores, each rejected with StoreErr=1, ByteEn=0000, no memory change, StoreCount unchanged, ErrSticky=1 afterwards:
  - sw @0x22;
  - sh @0x23;
  - StoreOp=11 @0x20;
  - sw @0x1000 (out of range).
- Same-word read-during-write: RData@0x30=0x0 before the edge with a sw 0xDEADBEEF @0x30 pending; 0xDEADBEEF after the edge.
- Reset mid-operation: assert reset asynchronously between edges after stores at 0x10 and 0x20 -> RData immediately 0; StoreCount=0; ErrSticky=0; a store held across the reset deassertion edge commits only on the first edge with reset low.

Source files
------------

// File: rtl/dm_store_unit.sv
// Memory-stage data memory with byte-lane store path: lane alignment, byte
// enables, misalignment/range rejection, error sticky bit and store counter.
module dm_store_unit #(
  parameter int unsigned DM_WORDS  = 1024,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  StoreOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [3:0]  ByteEn,
  output logic        StoreErr,
  output logic        ErrSticky,
  output logic [31:0] StoreCount
);

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } store_op_e;

  store_op_e              op;
  logic [ADDR_BITS-1:0]   idx;
  logic                   in_range;
  logic                   illegal;
  logic                   commit;
  logic [31:0]            aligned;
  logic [3:0]             be_raw;
  logic [31:0]            old_word;
  logic [31:0]            merged_d;

  logic [31:0]            mem_q [DM_WORDS];
  logic [DM_WORDS-1:0]    valid_q, valid_d;
  logic                   sticky_q, sticky_d;
  logic [31:0]            count_q, count_d;

  assign op       = store_op_e'(StoreOp);
  assign idx      = Addr[ADDR_BITS+1:2];
  assign in_range = (Addr[31:ADDR_BITS+2] == '0);

  always_comb begin
    aligned = WData;
    be_raw  = '0;
    illegal = 1'b0;
    unique case (op)
      OP_SW: begin
        aligned = WData;
        be_raw  = 4'b1111;
        illegal = (Addr[1:0] != 2'b00);
      end
      OP_SH: begin
        aligned = {WData[15:0], WData[15:0]};
        be_raw  = Addr[1] ? 4'b1100 : 4'b0011;
        illegal = Addr[0];
      end
      OP_SB: begin
        aligned = {4{WData[7:0]}};
        be_raw  = 4'b0001 << Addr[1:0];
        illegal = 1'b0;
      end
      OP_RSV: begin
        aligned = WData;
        be_raw  = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign StoreErr = MemWrite && (illegal || !in_range);
  assign commit   = MemWrite && !StoreErr;
  assign ByteEn   = commit ? be_raw : '0;

  // A per-word valid bit gives the all-zero reset image: the array itself is
  // never reset, and invalid words read (and merge) as zero.
  assign old_word = valid_q[idx] ? mem_q[idx] : '0;
  assign RData    = old_word;

  always_comb begin
    merged_d = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ByteEn[i]) merged_d[8*i +: 8] = aligned[8*i +: 8];
    end
  end

  always_comb begin
    valid_d  = valid_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    if (commit) begin
      valid_d[idx] = 1'b1;
      count_d      = count_q + 32'd1;
    end
    if (StoreErr) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !reset) mem_q[idx] <= merged_d;
  end

  assign ErrSticky  = sticky_q;
  assign StoreCount = count_q;

endmodule

// File: tb/tb_dm_store_unit.sv
// Bench for dm_store_unit: byte-addressed memory model checked every cycle,
// plus directed stores with hand-computed expectations.
module tb_dm_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [1:0]  StoreOp;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic [3:0]  ByteEn;
  logic        StoreErr;
  logic        ErrSticky;
  logic [31:0] StoreCount;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          cmp_en = 1'b0;

  dm_store_unit #(.DM_WORDS(1024), .ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .StoreOp(StoreOp),
    .Addr(Addr), .WData(WData), .RData(RData), .ByteEn(ByteEn),
    .StoreErr(StoreErr), .ErrSticky(ErrSticky), .StoreCount(StoreCount)
  );

  always #5 clk = ~clk;

  // Model: 4 KiB byte array, little-endian words.
  logic [7:0]  mbytes [4096];
  bit          m_sticky;
  logic [31:0] m_count;

  function automatic int unsigned op_size(input logic [1:0] op);
    case (op)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [1:0] op, input logic [31:0] a);
    int unsigned sz = op_size(op);
    if (sz == 0) return 1'b0;
    if (a % sz != 0) return 1'b0;
    return a < 32'd4096;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [1:0] op,
                                        input logic [31:0] a);
    logic [3:0] be = '0;
    if (we && is_legal(op, a))
      for (int unsigned k = 0; k < op_size(op); k++) be[(a + k) % 4] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    int unsigned base = (a % 4096) & ~32'd3;
    return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;
      m_sticky = 1'b0;
      m_count  = '0;
    end else if (MemWrite) begin
      if (is_legal(StoreOp, Addr)) begin
        for (int unsigned k = 0; k < op_size(StoreOp); k++)
          mbytes[Addr + k] = WData[8*k +: 8];
        m_count = m_count + 32'd1;
      end else begin
        m_sticky = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_rdata",  RData, exp_rdata(Addr));
      chk("m_byteen", {28'd0, ByteEn}, {28'd0, exp_be(MemWrite, StoreOp, Addr)});
      chk("m_err",    {31'd0, StoreErr},
          {31'd0, MemWrite && !is_legal(StoreOp, Addr)});
      chk("m_sticky", {31'd0, ErrSticky}, {31'd0, m_sticky});
      chk("m_count",  StoreCount, m_count);
    end
  end

  task automatic drive(input logic we, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    MemWrite = we; StoreOp = op; Addr = a; WData = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; StoreOp = 2'b00; Addr = '0; WData = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    Addr = 32'h0;   #1 chk("rst_rd_000", RData, 32'h0);
    Addr = 32'h7FC; #1 chk("rst_rd_7fc", RData, 32'h0);
    Addr = 32'hFFC; #1 chk("rst_rd_ffc", RData, 32'h0);
    chk("rst_count", StoreCount, 32'h0);
    chk("rst_sticky", {31'd0, ErrSticky}, 32'h0);

    drive(1, 2'b00, 32'h10, 32'h12345678);
    chk("sw_be", {28'd0, ByteEn}, 32'hF);
    drive(0, 2'b00, 32'h10, 32'h0);
    chk("sw_rd", RData, 32'h12345678);
    chk("sw_cnt", StoreCount, 32'd1);

    drive(1, 2'b00, 32'h20, 32'hAABBCCDD);
    drive(1, 2'b10, 32'h21, 32'h00000011);
    chk("sb_be", {28'd0, ByteEn}, 32'b0010);
    drive(1, 2'b01, 32'h22, 32'h00002233);
    chk("sh_be", {28'd0, ByteEn}, 32'b1100);
    drive(0, 2'b00, 32'h20, 32'h0);
    chk("merge_rd", RData, 32'h223311DD);
    // One earlier store at 0x10 plus these three.
    chk("merge_cnt", StoreCount, 32'd4);

    drive(1, 2'b00, 32'h22, 32'hFFFFFFFF);
    chk("sw_mis_err", {31'd0, StoreErr}, 32'h1);
    chk("sw_mis_be", {28'd0, ByteEn}, 32'h0);
    drive(1, 2'b01, 32'h23, 32'hFFFFFFFF);
    chk("sh_mis_err", {31'd0, StoreErr}, 32'h1);
    chk("sh_mis_be", {28'd0, ByteEn}, 32'h0);
    drive(1, 2'b11, 32'h20, 32'hFFFFFFFF);
    chk("rsv_err", {31'd0, StoreErr}, 32'h1);
    chk("rsv_be", {28'd0, ByteEn}, 32'h0);
    drive(1, 2'b00, 32'h1000, 32'hFFFFFFFF);
    chk("oor_err", {31'd0, StoreErr}, 32'h1);
    chk("oor_be", {28'd0, ByteEn}, 32'h0);
    chk("oor_rd_alias0", RData, 32'h0);
    drive(0, 2'b00, 32'h20, 32'h0);
    chk("rej_rd", RData, 32'h223311DD);
    chk("rej_cnt", StoreCount, 32'd4);
    chk("rej_sticky", {31'd0, ErrSticky}, 32'h1);

    drive(1, 2'b10, 32'hFFF, 32'h000000A5);
    chk("sb_top_be", {28'd0, ByteEn}, 32'b1000);
    drive(0, 2'b00, 32'hFFC, 32'h0);
    chk("sb_top_rd", RData, 32'hA5000000);

    drive(1, 2'b00, 32'h30, 32'hDEADBEEF);
    chk("rdw_before", RData, 32'h0);
    drive(0, 2'b00, 32'h30, 32'h0);
    chk("rdw_after", RData, 32'hDEADBEEF);
    chk("rdw_cnt", StoreCount, 32'd6);

    #1 reset = 1'b1;
    #1 chk("arst_rd30", RData, 32'h0);
    Addr = 32'h10; #1 chk("arst_rd10", RData, 32'h0);
    Addr = 32'h20; #1 chk("arst_rd20", RData, 32'h0);
    chk("arst_cnt", StoreCount, 32'h0);
    chk("arst_sticky", {31'd0, ErrSticky}, 32'h0);
    MemWrite = 1'b1; StoreOp = 2'b00; Addr = 32'h10; WData = 32'hCAFEF00D;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("hold_rd_pre", RData, 32'h0);
    chk("hold_cnt_pre", StoreCount, 32'h0);
    @(posedge clk);
    #1 chk("hold_rd_post", RData, 32'hCAFEF00D);
    chk("hold_cnt_post", StoreCount, 32'd1);
    MemWrite = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
